// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial two's-complement subtractor, D = A - B - Bin.
// One difference bit is produced per clock, LSB first, with the borrow chain
// held in a single flop. Operands and results use valid/ready handshakes.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V,
   output logic             Z
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             br_q, br_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] dsh_q, dsh_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic             bout_q, bout_d;
   logic             v_q, v_d;
   logic             z_q, z_d;

   logic             bit_d;
   logic             bit_br;
   logic [WIDTH-1:0] diff_full;

   // Handshake flags are pure decodes of the state register.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign D         = d_q;
   assign Bout      = bout_q;
   assign V         = v_q;
   assign Z         = z_q;

   // One full-subtractor cell working on the current LSBs of the operand shifters.
   always_comb begin
      bit_d     = a_q[0] ^ b_q[0] ^ br_q;
      bit_br    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      diff_full = {bit_d, dsh_q[WIDTH-1:1]};
   end

   // Next-state and datapath update; output registers load only when entering DONE.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      br_d    = br_q;
      a_d     = a_q;
      b_d     = b_q;
      dsh_d   = dsh_q;
      d_d     = d_q;
      bout_d  = bout_q;
      v_d     = v_q;
      z_d     = z_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = B;
               br_d    = Bin;
               idx_d   = '0;
               dsh_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d   = {1'b0, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            br_d  = bit_br;
            dsh_d = diff_full;
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(WIDTH - 1)) begin
               d_d     = diff_full;
               bout_d  = bit_br;
               v_d     = br_q ^ bit_br;
               z_d     = (diff_full == '0);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, shifters and result registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         br_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         dsh_q   <= '0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         br_q    <= br_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dsh_q   <= dsh_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         v_q     <= v_d;
         z_q     <= z_d;
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with a scoreboard of expected results.
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   typedef struct packed {
      logic [WIDTH-1:0] d;
      logic             bout;
      logic             v;
      logic             z;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] D;
   logic             Bout;
   logic             V;
   logic             Z;

   int   checks = 0;
   int   passes = 0;
   exp_t exp_q[$];

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D),
      .Bout      (Bout),
      .V         (V),
      .Z         (Z)
   );

   // 10-time-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference arithmetic using plain integer subtraction.
   function automatic exp_t model(input int a, input int b, input int bin);
      exp_t e;
      int   ud;
      int   sa;
      int   sb;
      int   sd;
      ud     = a - b - bin;
      sa     = (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
      sb     = (b >= (1 << (WIDTH - 1))) ? b - (1 << WIDTH) : b;
      sd     = sa - sb - bin;
      e.d    = ud[WIDTH-1:0];
      e.bout = (ud < 0);
      e.v    = (sd < -(1 << (WIDTH - 1))) || (sd > (1 << (WIDTH - 1)) - 1);
      e.z    = (ud[WIDTH-1:0] == 0);
      return e;
   endfunction

   // Present one operand set, push its expected result, and return after the accept edge.
   task automatic applyStimulus(input int a, input int b, input int bin, input bit push);
      A        = WIDTH'(a);
      B        = WIDTH'(b);
      Bin      = bin[0];
      in_valid = 1'b1;
      if (push) exp_q.push_back(model(a, b, bin));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Count edges after accept until out_valid shows up, bounded by a cycle budget.
   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (!out_valid && cycles < 40) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({in_ready, out_valid, D, Bout, V, Z} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 3'b000}) begin
         $display("[TB] FAIL reset_state got rdy=%b vld=%b D=%h Bo=%b V=%b Z=%b", in_ready,
                  out_valid, D, Bout, V, Z);
      end else passes++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // One operation with out_ready high: latency, result and return to IDLE.
   task automatic test_op(input string name, input int a, input int b, input int bin);
      int   cyc;
      exp_t e;
      out_ready = 1'b1;
      applyStimulus(a, b, bin, 1'b1);
      checks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL %s_busy in_ready=%b want 0", name, in_ready);
      else passes++;
      wait_valid(cyc);
      checks++;
      if (cyc !== WIDTH) $display("[TB] FAIL %s_latency got %0d want %0d", name, cyc, WIDTH);
      else passes++;
      if (exp_q.size() == 0) begin
         checks++;
         $display("[TB] FAIL %s_scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         checks++;
         if ({D, Bout, V, Z} !== {e.d, e.bout, e.v, e.z}) begin
            $display("[TB] FAIL %s_result got D=%h Bo=%b V=%b Z=%b want D=%h Bo=%b V=%b Z=%b",
                     name, D, Bout, V, Z, e.d, e.bout, e.v, e.z);
         end else passes++;
      end
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         $display("[TB] FAIL %s_idle got rdy=%b vld=%b want rdy=1 vld=0", name, in_ready,
                  out_valid);
      end else passes++;
   endtask

   // Hold out_ready low in DONE while offering new operands; nothing may move.
   task automatic test_backpressure();
      int   cyc;
      exp_t e;
      logic [WIDTH+2:0] held;
      out_ready = 1'b0;
      applyStimulus(7, 2, 1, 1'b1);
      wait_valid(cyc);
      checks++;
      if (cyc !== WIDTH) $display("[TB] FAIL bp_latency got %0d want %0d", cyc, WIDTH);
      else passes++;
      if (exp_q.size() == 0) begin
         checks++;
         $display("[TB] FAIL bp_scoreboard empty");
         e = '0;
      end else e = exp_q.pop_front();
      held     = {e.d, e.bout, e.v, e.z};
      A        = 4'hF;
      B        = 4'h1;
      Bin      = 1'b0;
      in_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({out_valid, in_ready, D, Bout, V, Z} !== {2'b10, held}) begin
            $display("[TB] FAIL bp_hold%0d got vld=%b rdy=%b D=%h Bo=%b V=%b Z=%b want %b", k,
                     out_valid, in_ready, D, Bout, V, Z, {2'b10, held});
         end else passes++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         $display("[TB] FAIL bp_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready,
                  out_valid);
      end else passes++;
      test_op("bp_next", 10, 3, 0);
   endtask

   // Reset pulse during RUN at bit index 2 aborts the operation silently.
   task automatic test_reset_abort();
      bit seen;
      out_ready = 1'b1;
      applyStimulus(6, 1, 0, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      checks++;
      if ({in_ready, out_valid, D, Bout, V, Z} !== {1'b1, 1'b0, {WIDTH{1'b0}}, 3'b000}) begin
         $display("[TB] FAIL abort_reset_state got rdy=%b vld=%b D=%h Bo=%b V=%b Z=%b",
                  in_ready, out_valid, D, Bout, V, Z);
      end else passes++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int k = 0; k < WIDTH + 4; k++) begin
         if (out_valid) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      checks++;
      if (seen !== 1'b0) $display("[TB] FAIL abort_no_valid got out_valid=1 want never");
      else passes++;
      test_op("after_abort", 12, 4, 0);
   endtask

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      A         = '0;
      B         = '0;
      Bin       = 1'b0;
      test_reset();
      test_op("sub_9_3", 9, 3, 0);
      test_op("sub_3_9", 3, 9, 0);
      test_op("sub_5_5", 5, 5, 0);
      test_op("sub_0_0_bin", 0, 0, 1);
      test_op("sub_8_1", 8, 1, 0);
      test_backpressure();
      test_reset_abort();
      for (int k = 0; k < 6; k++) begin
         test_op("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1)));
      end
      checks++;
      if (exp_q.size() != 0) $display("[TB] FAIL scoreboard_drain left=%0d want 0", exp_q.size());
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
